// File: rtl/seq_squarer_if.sv
// Operand/result handshake bundle for seq_squarer.
// master = producer/consumer side, slave = squarer.
interface seq_squarer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   n;
  logic               sign;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] square;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output n,
    output sign,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  square,
    input  out_valid
  );

  modport slave (
    input  n,
    input  sign,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output square,
    output out_valid
  );
endinterface

// File: rtl/seq_squarer.sv
// Iterative shift-and-add squarer, signed/unsigned operand,
// valid/ready on both sides, one result bit-column per cycle.
module seq_squarer #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  seq_squarer_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [WIDTH-1:0]  mag_q;
  logic [WIDTH-1:0]  mag_d;
  logic [PW-1:0]     acc_q;
  logic [PW-1:0]     acc_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              in_ready_q;
  logic              in_ready_d;
  logic              out_valid_q;
  logic              out_valid_d;

  logic [WIDTH-1:0]  n_abs;
  logic [PW-1:0]     addend;
  logic              cnt_last;

  // Most negative input negates to 2^(WIDTH-1), which fits unsigned.
  always_comb begin
    n_abs = bus.n;
    if (bus.sign && bus.n[WIDTH-1]) begin
      n_abs = WIDTH'(-bus.n);
    end
  end

  always_comb begin
    addend = '0;
    if (mag_q[cnt_q]) begin
      addend = {{WIDTH{1'b0}}, mag_q} << cnt_q;
    end
  end

  assign cnt_last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mag_d   = n_abs;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_q + addend;
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs are registered copies of the next state.
  always_comb begin
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mag_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.square    = acc_q;

endmodule

// File: tb/tb_seq_squarer.sv
// Scoreboard bench for seq_squarer at WIDTH=4 and WIDTH=8.
// Expected squares come from plain integer arithmetic.
module tb_seq_squarer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_squarer_if #(.WIDTH(4)) if4 ();
  seq_squarer_if #(.WIDTH(8)) if8 ();

  seq_squarer #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave)
  );

  seq_squarer #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  longint unsigned exp4[$];
  longint unsigned exp8[$];
  int acc4[$];
  int acc8[$];
  int last4 = -1;
  bit b2b = 1'b0;

  logic       pv4 = 1'b0;
  logic       pr4 = 1'b0;
  logic [7:0] psq4 = '0;
  logic       pv8 = 1'b0;
  logic       pr8 = 1'b0;
  logic [15:0] psq8 = '0;

  function automatic longint unsigned ref_sq(
    int unsigned v, bit s, int w);
    longint x;
    x = longint'(v);
    if (s && v[w-1]) x = x - (longint'(1) << w);
    return longint'(x * x);
  endfunction

  task automatic check(string nm, longint unsigned act,
                       longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // WIDTH=4 monitor
  always @(negedge clk) begin
    if (reset) begin
      pv4 = 1'b0;
      pr4 = 1'b0;
    end else begin
      if (if4.in_valid && if4.in_ready) begin
        exp4.push_back(ref_sq(int'(if4.n), if4.sign, 4));
        acc4.push_back(cyc + 1);
        if (b2b && last4 >= 0)
          check("b2b_period", cyc + 1 - last4, 6);
        last4 = cyc + 1;
      end
      if (if4.out_valid && !pv4) begin
        if (acc4.size() == 0) check("w4_spurious_valid", 1, 0);
        else check("w4_latency", cyc - acc4.pop_front(), 4);
      end
      if (pv4 && pr4) check("w4_valid_drop", if4.out_valid, 0);
      if (pv4 && !pr4 && if4.out_valid)
        check("w4_hold", if4.square, psq4);
      if (if4.out_valid && if4.out_ready) begin
        if (exp4.size() == 0) check("w4_unexpected", 1, 0);
        else check("w4_square", if4.square, exp4.pop_front());
      end
      pv4  = if4.out_valid;
      pr4  = if4.out_ready;
      psq4 = if4.square;
    end
  end

  // WIDTH=8 monitor
  always @(negedge clk) begin
    if (reset) begin
      pv8 = 1'b0;
      pr8 = 1'b0;
    end else begin
      if (if8.in_valid && if8.in_ready) begin
        exp8.push_back(ref_sq(int'(if8.n), if8.sign, 8));
        acc8.push_back(cyc + 1);
      end
      if (if8.out_valid && !pv8) begin
        if (acc8.size() == 0) check("w8_spurious_valid", 1, 0);
        else check("w8_latency", cyc - acc8.pop_front(), 8);
      end
      if (pv8 && pr8) check("w8_valid_drop", if8.out_valid, 0);
      if (pv8 && !pr8 && if8.out_valid)
        check("w8_hold", if8.square, psq8);
      if (if8.out_valid && if8.out_ready) begin
        if (exp8.size() == 0) check("w8_unexpected", 1, 0);
        else check("w8_square", if8.square, exp8.pop_front());
      end
      pv8  = if8.out_valid;
      pr8  = if8.out_ready;
      psq8 = if8.square;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(int unsigned v, bit s);
    int i;
    i = 0;
    while (!if4.in_ready && i < 50) begin
      tick();
      i++;
    end
    if (!if4.in_ready) check("w4_ready_timeout", 0, 1);
    if4.n        = 4'(v);
    if4.sign     = s;
    if4.in_valid = 1'b1;
    tick();
    if4.in_valid = 1'b0;
  endtask

  task automatic send8(int unsigned v, bit s);
    int i;
    i = 0;
    while (!if8.in_ready && i < 50) begin
      tick();
      i++;
    end
    if (!if8.in_ready) check("w8_ready_timeout", 0, 1);
    if8.n        = 8'(v);
    if8.sign     = s;
    if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
  endtask

  task automatic drain(int budget);
    int i;
    i = 0;
    while ((exp4.size() != 0 || exp8.size() != 0) && i < budget) begin
      tick();
      i++;
    end
    if (exp4.size() != 0 || exp8.size() != 0)
      check("drain_timeout", exp4.size() + exp8.size(), 0);
    tick();
  endtask

  task automatic chk_idle(string nm);
    check({nm, "_in_ready4"}, if4.in_ready, 1);
    check({nm, "_out_valid4"}, if4.out_valid, 0);
    check({nm, "_square4"}, if4.square, 0);
    check({nm, "_in_ready8"}, if8.in_ready, 1);
    check({nm, "_out_valid8"}, if8.out_valid, 0);
    check({nm, "_square8"}, if8.square, 0);
  endtask

  initial begin
    int wcnt;
    if4.n = '0; if4.sign = 1'b0;
    if4.in_valid = 1'b0; if4.out_ready = 1'b1;
    if8.n = '0; if8.sign = 1'b0;
    if8.in_valid = 1'b0; if8.out_ready = 1'b1;

    repeat (3) tick();
    reset = 1'b0;
    chk_idle("reset");

    send4(15, 0);
    drain(40);

    for (int k = 0; k < 16; k++) begin
      send4(k, 0);
      drain(40);
    end

    send4(4'b1000, 1); drain(40);
    send4(4'b1111, 1); drain(40);
    send4(4'b0111, 1); drain(40);
    send4(4'b1111, 0); drain(40);

    send8(255, 0);  drain(60);
    send8(8'h80, 1); drain(60);
    for (int k = 0; k < 6; k++) begin
      send8($urandom_range(0, 255), 1'($urandom_range(0, 1)));
      drain(60);
    end

    for (int k = 0; k < 20; k++) begin
      send4($urandom_range(0, 15), 1'($urandom_range(0, 1)));
      drain(40);
    end

    // Backpressure window with an ignored offer in the middle
    if4.out_ready = 1'b0;
    send4(9, 1'b0);
    wcnt = 0;
    while (!if4.out_valid && wcnt < 20) begin
      tick();
      wcnt++;
    end
    check("bp_reached_done", if4.out_valid, 1);
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", if4.out_valid, 1);
      check("bp_square", if4.square, ref_sq(9, 0, 4));
      check("bp_in_ready", if4.in_ready, 0);
      if (k == 3) begin
        if4.n = 4'd3;
        if4.in_valid = 1'b1;
      end else begin
        if4.in_valid = 1'b0;
      end
      tick();
    end
    if4.in_valid = 1'b0;
    if4.out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", if4.in_ready, 1);
    check("bp_release_valid", if4.out_valid, 0);
    drain(40);

    // Back-to-back with changing operand every cycle
    b2b = 1'b1;
    last4 = -1;
    if4.in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if4.n    = 4'($urandom_range(0, 15));
      if4.sign = 1'($urandom_range(0, 1));
      tick();
    end
    if4.in_valid = 1'b0;
    drain(40);
    b2b = 1'b0;

    // Abort mid-calculation
    send4(13, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp4.delete(); acc4.delete();
    exp8.delete(); acc8.delete();
    chk_idle("abort");
    send4(5, 0);
    drain(40);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_squarer.md
# seq_squarer

Parametrised iterative squarer with signed/unsigned mode and a valid/ready handshake on both sides. It replaces fixed-width combinational square lookup tables where operand width grows beyond what a case table supports. A WIDTH-bit operand is accepted, squared by shift-and-add over WIDTH cycles, and the exact 2*WIDTH-bit result is held until the consumer takes it. It sits between an operand producer and any downstream arithmetic or display stage.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock, reset sampled on clk rising edge.
- n  input  WIDTH  operand; sampled only on the acceptance edge.
- sign  input  1  0 = n unsigned, 1 = n two's complement; sampled with n.
- in_valid  input  1  producer offers n/sign.
- in_ready  output  1  block can accept; high only in IDLE.
- square  output  2*WIDTH  exact square of the accepted operand; unsigned.
- out_valid  output  1  square is final; high only in DONE.
- out_ready  input  1  consumer takes square.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1, out_valid=0. On in_valid=1 at an edge (acceptance): mag <= (sign && n[WIDTH-1]) ? -n : n (WIDTH-bit unsigned magnitude), acc <= 0, cnt <= 0, go CALC.
- Magnitude of the most negative value (n = 100..0, sign=1) is 2^(WIDTH-1), representable in WIDTH unsigned bits; no special case.
- CALC: each edge, if mag[cnt]=1 then acc <= acc + (mag << cnt); cnt <= cnt+1. After the edge with cnt=WIDTH-1, go DONE. Adder width 2*WIDTH; no overflow possible (max (2^WIDTH-1)^2 < 2^(2*WIDTH)).
- DONE: out_valid=1, square=acc stable. On out_ready=1 at an edge go IDLE.
- in_valid in CALC or DONE: ignored; n/sign not captured; no queuing.
- out_ready outside DONE: ignored.
- square is driven from acc at all times; meaningful only while out_valid=1; after consumption it holds the last result until the next acceptance clears it.
- cnt width: clog2(WIDTH), minimum 1 bit.

## Timing
- Reset: state=IDLE, acc=0, mag=0, cnt=0; outputs square=0, out_valid=0, in_ready=1 in the cycle after the reset edge. in_valid is ignored while reset is high.
- Reset mid-CALC or mid-DONE: operation aborted, result discarded, no out_valid pulse; same values as above.
- Latency: acceptance at edge E0 gives out_valid=1 in the cycle after edge E0+WIDTH.
- out_valid stays high, with square unchanged, for as many cycles as out_ready stays low.
- With out_ready held high: consumed at edge E0+WIDTH+1, IDLE; next acceptance earliest at E0+WIDTH+2. Minimum issue period is WIDTH+2 cycles.
- in_ready and out_valid are decoded directly from the state register (glitch-free, no combinational path from in_valid/out_ready).

## Test plan
- WIDTH=4, reset then n=15, sign=0, one-cycle in_valid, out_ready=1 -> square=225, out_valid high exactly 1 cycle, 4 cycles after the acceptance edge. Also sweep all 16 values in unsigned mode -> k*k each, including 0->0.
- WIDTH=4, sign=1: n=4'b1000 -> 64; n=4'b1111 -> 1; n=4'b0111 -> 49. Same n=4'b1111 with sign=0 -> 225.
- WIDTH=8: n=255, sign=0 -> 65025; n=8'h80, sign=1 -> 16384; latency 8 cycles.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and square stable. in_valid pulsed with n=3 during that window is ignored, and in_ready=0. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Back-to-back: in_valid and out_ready held high, n changing every cycle, WIDTH=4 -> accepts every 6 cycles. Each result equals the square of the n present on its acceptance edge.
- Reset asserted at CALC cycle 2 of n=13 -> next cycle state IDLE, square=0, out_valid=0, in_ready=1. A following n=5 gives 25 with normal latency.
